bit_serial_subtractor: RTL and testbench
========================================

Name: bit_serial_subtractor

Overview:
- Computes diff = a - b for two WIDTH-bit two's-complement operands, one bit per clock, LSB first.
- Uses a single full-adder bit cell (a_i + ~b_i + carry) and a registered carry/borrow flip-flop.
- It is the subtracting counterpart of the team's combinational adder cells.
- Intended as a low-area arithmetic unit behind a start/done handshake in the lab datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; result outputs valid from this cycle.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrow  output  1  1 when unsigned a < b; equals the inverted final carry.
- overflow  output  1  signed overflow; carry into MSB XOR carry out of MSB.
- zero  output  1  1 when diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; diff=0, borrow=0, overflow=0, zero=0, busy=0, done=0; internal shift registers, carry FF and bit counter all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge T:
  - latch a into shift reg A and b into shift reg B;
  - carry FF = 1, which supplies the +1 of ~b+1;
  - bit counter = 0; go to SHIFT.
- IDLE, start=0: stay. Result outputs hold their last values.
- SHIFT, each edge:
  - s = A[0] ^ ~B[0] ^ c;
  - c_next = majority(A[0], ~B[0], c);
  - shift A and B right by 1;
  - shift internal result reg right, inserting s at the MSB;
  - counter += 1.
  - The carry into the MSB is captured in a flag when counter == WIDTH-1.
- After the WIDTH-th SHIFT edge (counter reaches WIDTH): go to DONE. Register diff, borrow = ~c_final, overflow = c_into_msb ^ c_final, and zero.
- DONE: done=1 for exactly this one cycle, then IDLE. busy stays high during DONE.
- Latency: start sampled at edge T; done high in the cycle following edge T+WIDTH+1, i.e. WIDTH+1 edges after acceptance. The next start is accepted at the earliest 1 cycle after done.
- diff, borrow, overflow and zero change only on the DONE transition and are stable otherwise.
- start while busy (SHIFT or DONE): ignored, no queuing, operands unchanged. a and b may change freely after acceptance.
- Reset mid-operation: immediate abort to reset values; no done pulse.
- Boundaries:
  - b = 0 gives borrow = 0.
  - a = b gives zero = 1, borrow = 0.
  - Most-negative minus positive gives overflow = 1.

Optional Feature:
- Macro: ADDSUB_MODE_EN.
- Defined:
  - Extra port sub (input, 1), captured with the operands on an accepted start.
  - sub=1: subtract exactly as above.
  - sub=0: add. The B bit is used uninverted and the initial carry is 0.
  - The borrow output then reports carry out (non-inverted). overflow and zero keep the same definitions.
- Undefined: no sub port; the block always subtracts.

Test Plan (WIDTH=8):
- a=0x35, b=0x12, start pulse -> done exactly 9 edges after the accepting edge; diff=0x23, borrow=0, overflow=0, zero=0; busy high throughout.
- a=0x00, b=0x01 -> diff=0xFF, borrow=1, overflow=0, zero=0.
- a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow=0; then a=0x7F, b=0xFF -> diff=0x80, overflow=1, borrow=1.
- a=0x42, b=0x42 -> diff=0x00, zero=1, borrow=0; previous results held until this done.
- start re-pulsed with a=0x01, b=0x01 at cycle 3 of an operation on 0x35/0x12 -> ignored; result still 0x23, single done pulse.
- rst_n low at cycle 4 of an operation -> all outputs 0 immediately, no done; a fresh start after release gives a correct result. With ADDSUB_MODE_EN and sub=0: 0xF0 + 0x20 -> diff=0x10, borrow (carry)=1.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: LSB-first serial a - b with one full-adder cell and a carry FF.
// Optional ADDSUB_MODE_EN adds a sub input selecting add (0) or subtract (1).
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ADDSUB_MODE_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_c, r_cmsb, r_busy, r_done, r_borrow, r_overflow, r_zero;
    logic             w_inv, w_cin, w_bb, w_s, w_co;

`ifdef ADDSUB_MODE_EN
    logic r_sub;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sub <= 1'b0;
        else if (r_state == IDLE && start)
            r_sub <= sub;
    end
    assign w_inv = r_sub;
    assign w_cin = sub;
`else
    assign w_inv = 1'b1;
    assign w_cin = 1'b1;
`endif

    assign w_bb = r_b[0] ^ w_inv;
    assign w_s  = r_a[0] ^ w_bb ^ r_c;
    assign w_co = (r_a[0] & w_bb) | (r_a[0] & r_c) | (w_bb & r_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_c        <= 1'b0;
            r_cmsb     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_c     <= w_cin;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= SHIFT;
                end
                SHIFT: if (r_cnt == CW'(WIDTH)) begin
                    r_diff     <= r_res;
                    r_borrow   <= w_inv ? ~r_c : r_c;
                    r_overflow <= r_cmsb ^ r_c;
                    r_zero     <= (r_res == '0);
                    r_done     <= 1'b1;
                    r_state    <= DONE;
                end else begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_res <= {w_s, r_res[WIDTH-1:1]};
                    r_c   <= w_co;
                    r_cnt <= r_cnt + 1'b1;
                    // carry entering the MSB cell, needed for signed overflow
                    if (r_cnt == CW'(WIDTH - 1))
                        r_cmsb <= r_c;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign diff     = r_diff;
    assign borrow   = r_borrow;
    assign overflow = r_overflow;
    assign zero     = r_zero;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb_bit_serial_subtractor: directed vectors with hand-computed results for the serial subtractor.
module tb_bit_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, borrow, overflow, zero;
    logic [7:0] diff;
`ifdef ADDSUB_MODE_EN
    logic       sub = 1'b1;
`endif
    int n_cmp = 0;
    int n_fail = 0;

    bit_serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ADDSUB_MODE_EN
        .sub(sub),
`endif
        .a(a), .b(b), .busy(busy), .done(done), .diff(diff),
        .borrow(borrow), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_diff"}, {24'd0, diff}, 32'h0);
        chk({tag, "_flags"}, {28'd0, borrow, overflow, zero, busy}, 32'h0);
        chk({tag, "_done"}, {31'd0, done}, 32'h0);
    endtask

    // inj: cycle after acceptance at which a stray start with a=b=1 is pulsed (0 = none)
    task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic [7:0] ed, input logic eb, input logic eo, input logic ez,
                      input int inj);
        logic [10:0] prev;
        int lat;
        bit busy_ok, hold_ok;
        prev = {diff, borrow, overflow, zero};
        busy_ok = 1;
        hold_ok = 1;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'h5A; b = 8'hC3;
        lat = 0;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 0;
            if ({diff, borrow, overflow, zero} !== prev) hold_ok = 0;
            if (inj != 0 && lat == inj) begin a = 8'h01; b = 8'h01; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_busy"}, {31'd0, busy_ok & busy}, 32'h1);
        chk({tag, "_hold"}, {31'd0, hold_ok}, 32'h1);
        chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, "_bor_ov_z"}, {29'd0, borrow, overflow, zero}, {29'd0, eb, eo, ez});
        @(posedge clk); #1;
        chk({tag, "_after"}, {30'd0, done, busy}, 32'h0);
        chk({tag, "_stable"}, {21'd0, diff, borrow, overflow, zero}, {21'd0, ed, eb, eo, ez});
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("idle");

        op("s35_12", 8'h35, 8'h12, 8'h23, 0, 0, 0, 0);
        op("s00_01", 8'h00, 8'h01, 8'hFF, 1, 0, 0, 0);
        op("s80_01", 8'h80, 8'h01, 8'h7F, 0, 1, 0, 0);
        op("s7F_FF", 8'h7F, 8'hFF, 8'h80, 1, 1, 0, 0);
        op("s42_42", 8'h42, 8'h42, 8'h00, 0, 0, 1, 0);
        op("sB0_00", 8'hB0, 8'h00, 8'hB0, 0, 0, 0, 0);
        op("restart", 8'h35, 8'h12, 8'h23, 0, 0, 0, 3);

        @(negedge clk);
        a = 8'h35; b = 8'h12; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int nd = 0;
            repeat (12) begin @(posedge clk); #1; if (done || busy) nd++; end
            chk("midrst_nodone", nd, 0);
        end
        op("sA0_30", 8'hA0, 8'h30, 8'h70, 0, 1, 0, 0);

`ifdef ADDSUB_MODE_EN
        sub = 1'b0;
        op("addF0_20", 8'hF0, 8'h20, 8'h10, 1, 0, 0, 0);
        sub = 1'b1;
        op("subF0_20", 8'hF0, 8'h20, 8'hD0, 0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
